// File: rtl/demux_route_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : demux_route_sequencer
//  Purpose  : Upstream sequencer for a 3-way output demux. It accepts one
//             valid/ready stream and splits it into up to three consecutive
//             bursts of len_1, len_2 and len_3 beats. Each beat is registered
//             in a 1-entry output buffer and presented to the demux with the
//             matching select (00/01/10; 11 = idle, all demux outputs zero).
//  Ports    : clock, reset (sync, active-high)
//             start, stop        pass control (stop used only when looping)
//             len_1..len_3       burst lengths, latched on an accepted start
//             in_data/in_valid/in_ready    upstream stream
//             out_data/out_valid/sel       registered beat + demux select
//             dst_ready[2:0]     ready of consumers 1..3 (bit0 = dest 1)
//             busy, done         status, done is a one-cycle pulse
//  Options  : ROUTE_LOOP_EN - when defined, passes repeat with the latched
//             lengths until stop has been seen; otherwise stop is ignored.
//  Revision : 1.0 - initial release
// ============================================================================
module demux_route_sequencer #(
    parameter int DATA_W = 16,
    parameter int LEN_W  = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic [LEN_W-1:0]  len_1,
    input  logic [LEN_W-1:0]  len_2,
    input  logic [LEN_W-1:0]  len_3,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic [1:0]        sel,
    input  logic [2:0]        dst_ready,
    output logic              busy,
    output logic              done
);

    // State encoding equals the demux select code, so sel is the state register.
    localparam logic [1:0] c_SEND1 = 2'b00;
    localparam logic [1:0] c_SEND2 = 2'b01;
    localparam logic [1:0] c_SEND3 = 2'b10;
    localparam logic [1:0] c_IDLE  = 2'b11;

    logic [1:0]        r_state;
    logic [LEN_W-1:0]  r_len1;
    logic [LEN_W-1:0]  r_len2;
    logic [LEN_W-1:0]  r_len3;
    logic [LEN_W-1:0]  r_in_cnt;
    logic [LEN_W-1:0]  r_out_cnt;
    logic [DATA_W-1:0] r_out_data;
    logic              r_out_valid;
    logic              r_done;
`ifdef ROUTE_LOOP_EN
    logic              r_stop_seen;
`else
    logic              w_unused_stop;
    assign w_unused_stop = stop;
`endif

    logic [LEN_W-1:0]  w_len_cur;
    logic              w_dst_rdy;
    logic              w_out_fire;
    logic              w_in_ready;
    logic              w_in_fire;
    logic              w_burst_end;
    logic [1:0]        w_next;
    logic [1:0]        w_first_new;
    logic [1:0]        w_first_lat;

    // First destination with a nonzero length, or IDLE when all are zero.
    function automatic logic [1:0] first_dest(input logic [LEN_W-1:0] a,
                                              input logic [LEN_W-1:0] b,
                                              input logic [LEN_W-1:0] c);
        if (a != '0)      first_dest = c_SEND1;
        else if (b != '0) first_dest = c_SEND2;
        else if (c != '0) first_dest = c_SEND3;
        else              first_dest = c_IDLE;
    endfunction

    assign w_first_new = first_dest(len_1, len_2, len_3);
    assign w_first_lat = first_dest(r_len1, r_len2, r_len3);

    // Length and consumer-ready of the destination currently selected;
    // the other dst_ready bits never influence the handshake.
    always_comb begin
        w_len_cur = '0;
        w_dst_rdy = 1'b0;
        case (r_state)
            c_SEND1: begin w_len_cur = r_len1; w_dst_rdy = dst_ready[0]; end
            c_SEND2: begin w_len_cur = r_len2; w_dst_rdy = dst_ready[1]; end
            c_SEND3: begin w_len_cur = r_len3; w_dst_rdy = dst_ready[2]; end
            default: ;
        endcase
    end

    // Next nonzero destination after the current burst.
    always_comb begin
        w_next = c_IDLE;
        case (r_state)
            c_SEND1: begin
                if (r_len2 != '0)      w_next = c_SEND2;
                else if (r_len3 != '0) w_next = c_SEND3;
            end
            c_SEND2: begin
                if (r_len3 != '0)      w_next = c_SEND3;
            end
            default: ;
        endcase
    end

    assign w_out_fire  = r_out_valid & w_dst_rdy;
    // Once every beat of the burst is accepted, in_ready stays low until the
    // burst drains, so no beat ever crosses into the next destination.
    assign w_in_ready  = (r_state != c_IDLE) & (r_in_cnt < w_len_cur) &
                         (~r_out_valid | w_out_fire);
    assign w_in_fire   = in_valid & w_in_ready;
    assign w_burst_end = w_out_fire & ((r_out_cnt + LEN_W'(1)) == w_len_cur);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= c_IDLE;
            r_len1      <= '0;
            r_len2      <= '0;
            r_len3      <= '0;
            r_in_cnt    <= '0;
            r_out_cnt   <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_done      <= 1'b0;
`ifdef ROUTE_LOOP_EN
            r_stop_seen <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;

            // 1-entry output buffer: load on accept, empty on consume.
            if (w_in_fire) begin
                r_out_data  <= in_data;
                r_out_valid <= 1'b1;
            end else if (w_out_fire) begin
                r_out_valid <= 1'b0;
            end

            if (w_in_fire)  r_in_cnt  <= r_in_cnt + LEN_W'(1);
            if (w_out_fire) r_out_cnt <= r_out_cnt + LEN_W'(1);

`ifdef ROUTE_LOOP_EN
            r_stop_seen <= r_stop_seen | stop;
`endif

            case (r_state)
                c_IDLE: begin
`ifdef ROUTE_LOOP_EN
                    r_stop_seen <= start & stop;
`endif
                    if (start) begin
                        r_len1    <= len_1;
                        r_len2    <= len_2;
                        r_len3    <= len_3;
                        r_in_cnt  <= '0;
                        r_out_cnt <= '0;
                        r_state   <= w_first_new;
                        // Empty pass: stay idle and just report completion.
                        if (w_first_new == c_IDLE) r_done <= 1'b1;
                    end
                end
                default: begin
                    if (w_burst_end) begin
                        // Counters restart on every burst boundary, including a
                        // loop back into the same single destination.
                        r_in_cnt  <= '0;
                        r_out_cnt <= '0;
                        if (w_next != c_IDLE) begin
                            r_state <= w_next;
                        end else begin
`ifdef ROUTE_LOOP_EN
                            if (!(r_stop_seen | stop)) begin
                                r_state <= w_first_lat;
                            end else begin
                                r_state <= c_IDLE;
                                r_done  <= 1'b1;
                            end
`else
                            r_state <= c_IDLE;
                            r_done  <= 1'b1;
`endif
                        end
                    end
                end
            endcase
        end
    end

    assign in_ready  = w_in_ready;
    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign sel       = r_state;
    assign busy      = (r_state != c_IDLE);
    assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_demux_route_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_demux_route_sequencer
//  Purpose  : Directed self-checking bench for demux_route_sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_demux_route_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        stop  = 1'b0;
    logic [7:0]  len_1 = '0;
    logic [7:0]  len_2 = '0;
    logic [7:0]  len_3 = '0;
    logic [15:0] in_data = 16'h1000;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] out_data;
    logic        out_valid;
    logic [1:0]  sel;
    logic [2:0]  dst_ready = '0;
    logic        busy;
    logic        done;

    demux_route_sequencer #(.DATA_W(16), .LEN_W(8)) dut (
        .clock(clock), .reset(reset), .start(start), .stop(stop),
        .len_1(len_1), .len_2(len_2), .len_3(len_3),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .sel(sel),
        .dst_ready(dst_ready), .busy(busy), .done(done)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Event logs captured at each rising edge (pre-update values).
    logic [1:0]  f_sel[$];
    logic [15:0] f_data[$];
    int          f_cyc[$];
    logic [15:0] i_data[$];
    int          d_cyc[$];
    int          s_cyc[$];

    logic [3:0] rdy4;
    assign rdy4 = {1'b0, dst_ready};

    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (!reset) begin
            if (out_valid && rdy4[sel]) begin
                f_sel.push_back(sel);
                f_data.push_back(out_data);
                f_cyc.push_back(cyc);
            end
            if (in_valid && in_ready) begin
                i_data.push_back(in_data);
                in_data <= in_data + 16'd1;
            end
            if (done) d_cyc.push_back(cyc);
            if (start && !busy) s_cyc.push_back(cyc);
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic launch(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        len_1 = a; len_2 = b; len_3 = c;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input int d0, output bit ok);
        int n;
        ok = 1'b0;
        n  = 0;
        while (!ok && n < 300) begin
            if (d_cyc.size() > d0) ok = 1'b1;
            else begin step(); n++; end
        end
    endtask

    task automatic wait_fires(input int target, output bit ok);
        int n;
        ok = 1'b0;
        n  = 0;
        while (!ok && n < 300) begin
            if (f_sel.size() >= target) ok = 1'b1;
            else begin step(); n++; end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; dst_ready = 3'b111; in_valid = 1'b1;
        repeat (3) step();
        @(negedge clock);
        checks++; if (sel !== 2'b11)     begin errors++; $display("FAIL reset_sel: got %b want 11", sel); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (out_data !== 16'h0) begin errors++; $display("FAIL reset_out_data: got %h want 0000", out_data); end
        checks++; if (in_ready !== 1'b0)  begin errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_busy_done: got %b%b want 00", busy, done); end
        in_valid = 1'b0;
        step();
        reset = 1'b0;
        step();
    endtask

    task automatic test_three_bursts();
        int f0, d0, s0, st;
        bit ok;
        logic [15:0] base;
        int exp_sel[6] = '{0, 0, 0, 1, 1, 2};
        int exp_off[6] = '{2, 3, 4, 6, 7, 9};
        f0 = f_sel.size(); d0 = d_cyc.size(); s0 = s_cyc.size();
        dst_ready = 3'b111; in_valid = 1'b1; base = in_data;
        launch(8'd3, 8'd2, 8'd1);
        wait_done(d0, ok);
        checks++; if (!ok) begin errors++; $display("FAIL basic_done_timeout: got no done want done"); end
        checks++; if (f_sel.size() - f0 != 6) begin errors++; $display("FAIL basic_fire_count: got %0d want 6", f_sel.size() - f0); end
        if (ok && f_sel.size() - f0 == 6 && s_cyc.size() > s0) begin
            st = s_cyc[s0];
            for (int k = 0; k < 6; k++) begin
                checks++;
                if (f_sel[f0+k] !== 2'(exp_sel[k]) || f_data[f0+k] !== base + 16'(k) || f_cyc[f0+k] - st != exp_off[k]) begin
                    errors++;
                    $display("FAIL basic_beat%0d: got sel=%b data=%h off=%0d want sel=%0d data=%h off=%0d",
                             k, f_sel[f0+k], f_data[f0+k], f_cyc[f0+k] - st, exp_sel[k], base + 16'(k), exp_off[k]);
                end
            end
            checks++; if (d_cyc[d0] - f_cyc[f0+5] != 1) begin errors++; $display("FAIL basic_done_latency: got %0d want 1", d_cyc[d0] - f_cyc[f0+5]); end
        end
        @(negedge clock);
        checks++; if (done !== 1'b0 || busy !== 1'b0 || sel !== 2'b11) begin errors++; $display("FAIL basic_after_done: got done=%b busy=%b sel=%b want 0 0 11", done, busy, sel); end
        step();
    endtask

    task automatic test_zero_len();
        int f0, d0, s0;
        bit ok;
        logic [15:0] base;
        f0 = f_sel.size(); d0 = d_cyc.size(); s0 = s_cyc.size();
        dst_ready = 3'b111; in_valid = 1'b1; base = in_data;
        launch(8'd0, 8'd4, 8'd0);
        wait_done(d0, ok);
        checks++; if (!ok || f_sel.size() - f0 != 4) begin errors++; $display("FAIL zl_count: got %0d fires done=%0b want 4 fires done", f_sel.size() - f0, ok); end
        if (ok && f_sel.size() - f0 == 4) begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (f_sel[f0+k] !== 2'b01 || f_data[f0+k] !== base + 16'(k)) begin
                    errors++; $display("FAIL zl_beat%0d: got sel=%b data=%h want 01 %h", k, f_sel[f0+k], f_data[f0+k], base + 16'(k));
                end
            end
            checks++; if (d_cyc[d0] - s_cyc[s0] != 6) begin errors++; $display("FAIL zl_done_time: got %0d want 6", d_cyc[d0] - s_cyc[s0]); end
        end
        step();
        // All lengths zero: done the cycle after start, never busy.
        d0 = d_cyc.size(); s0 = s_cyc.size(); f0 = f_sel.size();
        launch(8'd0, 8'd0, 8'd0);
        @(negedge clock);
        checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL zero_done: got done=%b busy=%b want 1 0", done, busy); end
        step();
        @(negedge clock);
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL zero_after: got done=%b busy=%b want 0 0", done, busy); end
        checks++; if (d_cyc.size() - d0 != 1 || f_sel.size() != f0) begin errors++; $display("FAIL zero_counts: got done=%0d fires=%0d want 1 0", d_cyc.size() - d0, f_sel.size() - f0); end
        step();
    endtask

    task automatic test_backpressure();
        int f0, d0, i0, n;
        bit ok;
        logic [15:0] base, hd;
        logic [1:0]  hs;
        f0 = f_sel.size(); d0 = d_cyc.size(); i0 = i_data.size();
        dst_ready = 3'b111; in_valid = 1'b1; base = in_data;
        launch(8'd4, 8'd0, 8'd0);
        n = 0;
        @(negedge clock);
        while (out_valid !== 1'b1 && n < 20) begin @(negedge clock); n++; end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_first_valid: got %b want 1", out_valid); end
        step();
        dst_ready = 3'b110;          // dest 1 stalls, others ready but unselected
        @(negedge clock);
        hd = out_data; hs = sel;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) @(negedge clock);
            checks++;
            if (out_valid !== 1'b1 || out_data !== hd || sel !== 2'b00 || hs !== 2'b00 || in_ready !== 1'b0) begin
                errors++; $display("FAIL bp_hold%0d: got v=%b d=%h sel=%b rdy=%b want 1 %h 00 0", k, out_valid, out_data, sel, in_ready, hd);
            end
        end
        checks++; if (hd !== base + 16'd1) begin errors++; $display("FAIL bp_held_data: got %h want %h", hd, base + 16'd1); end
        step();
        dst_ready = 3'b111;
        wait_done(d0, ok);
        checks++; if (!ok || f_sel.size() - f0 != 4 || i_data.size() - i0 != 4) begin
            errors++; $display("FAIL bp_counts: got out=%0d in=%0d done=%0b want 4 4 1", f_sel.size() - f0, i_data.size() - i0, ok);
        end
        if (f_sel.size() - f0 == 4) begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (f_data[f0+k] !== base + 16'(k) || f_sel[f0+k] !== 2'b00) begin
                    errors++; $display("FAIL bp_beat%0d: got %h sel=%b want %h 00", k, f_data[f0+k], f_sel[f0+k], base + 16'(k));
                end
            end
        end
        step();
    endtask

    task automatic test_toggle_valid();
        int f0, d0, i0, n;
        logic [15:0] base;
        int exp_sel[6] = '{0, 0, 1, 1, 2, 2};
        f0 = f_sel.size(); d0 = d_cyc.size(); i0 = i_data.size();
        dst_ready = 3'b111; in_valid = 1'b0; base = in_data;
        launch(8'd2, 8'd2, 8'd2);
        n = 0;
        while (d_cyc.size() == d0 && n < 200) begin
            in_valid = ~in_valid;
            step();
            n++;
        end
        in_valid = 1'b0;
        checks++; if (d_cyc.size() == d0) begin errors++; $display("FAIL tog_done_timeout: got no done want done"); end
        checks++; if (f_sel.size() - f0 != 6 || i_data.size() - i0 != 6) begin
            errors++; $display("FAIL tog_counts: got out=%0d in=%0d want 6 6", f_sel.size() - f0, i_data.size() - i0);
        end
        if (f_sel.size() - f0 == 6 && i_data.size() - i0 == 6) begin
            for (int k = 0; k < 6; k++) begin
                checks++;
                if (f_data[f0+k] !== i_data[i0+k] || f_data[f0+k] !== base + 16'(k) || f_sel[f0+k] !== 2'(exp_sel[k])) begin
                    errors++; $display("FAIL tog_beat%0d: got %h sel=%b want %h sel=%0d", k, f_data[f0+k], f_sel[f0+k], base + 16'(k), exp_sel[k]);
                end
            end
        end
        step();
    endtask

    task automatic test_reset_mid();
        int f0, d0, n;
        bit ok;
        logic [15:0] base;
        dst_ready = 3'b101; in_valid = 1'b1;
        launch(8'd1, 8'd3, 8'd0);
        n = 0;
        @(negedge clock);
        while (!(sel === 2'b01 && out_valid === 1'b1) && n < 20) begin @(negedge clock); n++; end
        checks++; if (sel !== 2'b01 || out_valid !== 1'b1) begin errors++; $display("FAIL rm_reach: got sel=%b v=%b want 01 1", sel, out_valid); end
        d0 = d_cyc.size();
        reset = 1'b1;
        @(negedge clock);
        checks++;
        if (sel !== 2'b11 || out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || out_data !== 16'h0) begin
            errors++; $display("FAIL rm_state: got sel=%b v=%b busy=%b done=%b d=%h want 11 0 0 0 0000", sel, out_valid, busy, done, out_data);
        end
        reset = 1'b0;
        repeat (3) step();
        checks++; if (d_cyc.size() != d0) begin errors++; $display("FAIL rm_no_done: got %0d pulses want 0", d_cyc.size() - d0); end
        f0 = f_sel.size();
        dst_ready = 3'b111; base = in_data;
        launch(8'd2, 8'd1, 8'd0);
        wait_done(d0, ok);
        checks++; if (!ok || f_sel.size() - f0 != 3) begin errors++; $display("FAIL rm_restart: got fires=%0d done=%0b want 3 1", f_sel.size() - f0, ok); end
        if (f_sel.size() - f0 == 3) begin
            checks++;
            if (f_sel[f0] !== 2'b00 || f_sel[f0+1] !== 2'b00 || f_sel[f0+2] !== 2'b01 ||
                f_data[f0] !== base || f_data[f0+2] !== base + 16'd2) begin
                errors++; $display("FAIL rm_restart_beats: got %b/%b/%b %h..%h want 00/00/01 %h..%h",
                                   f_sel[f0], f_sel[f0+1], f_sel[f0+2], f_data[f0], f_data[f0+2], base, base + 16'd2);
            end
        end
        step();
    endtask

    task automatic test_loop_stop();
        int f0, d0, nexp;
        bit ok;
        f0 = f_sel.size(); d0 = d_cyc.size();
        dst_ready = 3'b111; in_valid = 1'b1;
        launch(8'd1, 8'd1, 8'd1);
`ifdef ROUTE_LOOP_EN
        nexp = 6;
        wait_fires(f0 + 4, ok);
`else
        nexp = 3;
        wait_fires(f0 + 1, ok);
`endif
        checks++; if (!ok) begin errors++; $display("FAIL loop_progress: got %0d fires want more", f_sel.size() - f0); end
        stop = 1'b1;
        step();
        stop = 1'b0;
        wait_done(d0, ok);
        repeat (4) step();
        checks++; if (!ok || d_cyc.size() - d0 != 1) begin errors++; $display("FAIL loop_done: got %0d pulses want 1", d_cyc.size() - d0); end
        checks++; if (f_sel.size() - f0 != nexp) begin errors++; $display("FAIL loop_count: got %0d want %0d", f_sel.size() - f0, nexp); end
        if (f_sel.size() - f0 == nexp && d_cyc.size() - d0 == 1) begin
            for (int k = 0; k < nexp; k++) begin
                checks++;
                if (f_sel[f0+k] !== 2'(k % 3)) begin errors++; $display("FAIL loop_sel%0d: got %b want %0d", k, f_sel[f0+k], k % 3); end
            end
            checks++; if (d_cyc[d0] - f_cyc[f0+nexp-1] != 1) begin errors++; $display("FAIL loop_done_time: got %0d want 1", d_cyc[d0] - f_cyc[f0+nexp-1]); end
        end
        @(negedge clock);
        checks++; if (busy !== 1'b0 || sel !== 2'b11) begin errors++; $display("FAIL loop_idle: got busy=%b sel=%b want 0 11", busy, sel); end
    endtask

    initial begin
        test_reset();
        test_three_bursts();
        test_zero_len();
        test_backpressure();
        test_toggle_valid();
        test_reset_mid();
        test_loop_stop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
